// File: rtl/fifo_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_stream_pkg : shared types and constants for fifo_stream_reader  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package fifo_stream_pkg;

   localparam int C_BUF_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_stream_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_stream_buf : 2-entry register buffer with push/pop/count        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module fifo_stream_buf
   import fifo_stream_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [1:0]       count_q, count_d;

   // The head register always holds the oldest word, so it drives the stream directly.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({i_push, i_pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = i_data;
            else                 tail_d = i_data;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               head_d = i_data;
            end else begin
               head_d = tail_q;
               tail_d = i_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign o_head  = head_q;
   assign o_count = count_q;

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(i_push && !i_pop && (count_q == 2'(C_BUF_DEPTH))));

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_stream_reader : FIFO read-side consumer onto a valid/ready      |
// | stream. Optional word counter: FIFO_STREAM_READER_CNT_EN.            |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             fifo_empty,
   output logic             fifo_rd,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy
`ifdef FIFO_STREAM_READER_CNT_EN
   ,
   output logic [15:0]      word_cnt
`endif
);

   if (BUF_DEPTH != C_BUF_DEPTH) begin : g_bad_depth
      $error("fifo_stream_reader: BUF_DEPTH must be 2");
   end

   state_e     state_q, state_d;
   logic       inflight_q, inflight_d;
   logic [1:0] count;
   logic       pop;
   logic       issue;
   logic [2:0] occupancy;

   // Words already committed (buffered plus in flight) after this cycle's pop.
   assign pop        = m_valid & m_ready;
   assign occupancy  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue      = en & ~fifo_empty & (occupancy < 3'(C_BUF_DEPTH));
   assign fifo_rd    = issue & rst & (state_q != DRAIN);
   assign inflight_d = fifo_rd;
   assign m_valid    = (count != 2'd0);
   assign busy       = m_valid | inflight_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = ACTIVE;
         ACTIVE:  if (!en) state_d = busy ? DRAIN : IDLE;
         DRAIN: begin
            if (en)         state_d = ACTIVE;
            else if (!busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
      end
   end

   fifo_stream_buf #(
      .WIDTH (WIDTH)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_push  (inflight_q),
      .i_data  (fifo_dout),
      .i_pop   (pop),
      .o_head  (m_data),
      .o_count (count)
   );

`ifdef FIFO_STREAM_READER_CNT_EN
   logic [15:0] word_cnt_q, word_cnt_d;

   always_comb word_cnt_d = word_cnt_q + {15'd0, pop};

   always_ff @(posedge clk) begin
      if (!rst) word_cnt_q <= 16'd0;
      else      word_cnt_q <= word_cnt_d;
   end

   assign word_cnt = word_cnt_q;

   a_no_empty_read : assert property (@(posedge clk) disable iff (!rst)
      !(fifo_rd && fifo_empty));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_stream_reader : randomized bench with FIFO and stream model  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fifo_stream_reader;

   localparam int WIDTH    = 8;
   localparam int MEM_N    = 1024;
   localparam int S_IDLE   = 0;
   localparam int S_ACTIVE = 1;
   localparam int S_DRAIN  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             fifo_empty;
   logic             fifo_rd;
   logic [WIDTH-1:0] fifo_dout = '0;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic             busy;
`ifdef FIFO_STREAM_READER_CNT_EN
   logic [15:0]      word_cnt;
   logic [15:0]      m_wc;
`endif

   logic [WIDTH-1:0] mem [MEM_N];
   logic [9:0]       wr_ptr = '0;
   logic [9:0]       rd_ptr = '0;

   int total = 0;
   int bad   = 0;
   int rd_pulses;
   int beats;

   // Reference model state: buffered words, word in flight, controller mode.
   logic [WIDTH-1:0] bq[$];
   bit               m_infl;
   logic [WIDTH-1:0] m_infl_word;
   int               m_st;
   bit               m_data_rst;

   fifo_stream_reader #(
      .WIDTH     (WIDTH),
      .BUF_DEPTH (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_dout  (fifo_dout),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .busy       (busy)
`ifdef FIFO_STREAM_READER_CNT_EN
      ,
      .word_cnt   (word_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Source FIFO with registered read data.
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk) begin
      if (fifo_rd && !fifo_empty) begin
         fifo_dout <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 10'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [WIDTH-1:0] w);
      mem[wr_ptr] = w;
      wr_ptr      = wr_ptr + 10'd1;
   endtask

   // One clock: apply inputs, check outputs against the model, advance the model.
   task automatic step(input bit r, input bit e, input bit rdy);
      bit               exp_valid, exp_busy, pop, issue, exp_rd;
      int               cnt, occ;
      logic [WIDTH-1:0] nxt_word;
      rst     = r;
      en      = e;
      m_ready = rdy;
      #1;
      cnt       = bq.size();
      exp_valid = (cnt != 0);
      exp_busy  = exp_valid || m_infl;
      pop       = exp_valid && rdy;
      occ       = cnt + int'(m_infl) - int'(pop);
      issue     = e && !fifo_empty && (occ < 2);
      exp_rd    = issue && r && (m_st != S_DRAIN);
      chk("fifo_rd", {31'd0, fifo_rd}, {31'd0, exp_rd});
      chk("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
      chk("busy",    {31'd0, busy},    {31'd0, exp_busy});
      if (exp_valid)       chk("m_data", {24'd0, m_data}, {24'd0, bq[0]});
      else if (m_data_rst) chk("m_data_rst", {24'd0, m_data}, 32'd0);
`ifdef FIFO_STREAM_READER_CNT_EN
      chk("word_cnt", {16'd0, word_cnt}, {16'd0, m_wc});
`endif
      if (fifo_rd) rd_pulses++;
      if (pop)     beats++;
      nxt_word = mem[rd_ptr];
      @(posedge clk);
      if (!r) begin
         bq.delete();
         m_infl     = 1'b0;
         m_st       = S_IDLE;
         m_data_rst = 1'b1;
`ifdef FIFO_STREAM_READER_CNT_EN
         m_wc       = 16'd0;
`endif
      end else begin
         case (m_st)
            S_IDLE:   if (e) m_st = S_ACTIVE;
            S_ACTIVE: if (!e) m_st = exp_busy ? S_DRAIN : S_IDLE;
            default: begin
               if (e)              m_st = S_ACTIVE;
               else if (!exp_busy) m_st = S_IDLE;
            end
         endcase
         if (pop) begin
            void'(bq.pop_front());
`ifdef FIFO_STREAM_READER_CNT_EN
            m_wc = m_wc + 16'd1;
`endif
         end
         if (m_infl) begin
            bq.push_back(m_infl_word);
            m_data_rst = 1'b0;
         end
         m_infl      = exp_rd;
         m_infl_word = nxt_word;
      end
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached before completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bq.delete();
      m_infl      = 1'b0;
      m_infl_word = '0;
      m_st        = S_IDLE;
      m_data_rst  = 1'b1;
`ifdef FIFO_STREAM_READER_CNT_EN
      m_wc        = 16'd0;
`endif
      rd_pulses   = 0;
      beats       = 0;
      rst     = 1'b0;
      en      = 1'b1;
      m_ready = 1'b1;
      for (int i = 1; i <= 30; i++) push_word(8'(i));
      @(posedge clk);
      @(negedge clk);

      // Reset held with a non-empty FIFO and en=1.
      repeat (2) step(1'b0, 1'b1, 1'b1);

      // Streaming of 0x01..0x1E with an always-ready sink.
      beats = 0;
      repeat (34) step(1'b1, 1'b1, 1'b1);
      chk("stream_beats", beats, 30);

      // Backpressure window in the middle of a random stream.
      beats = 0;
      for (int i = 0; i < 20; i++) push_word(8'($urandom));
      repeat (4) step(1'b1, 1'b1, 1'b1);
      repeat (5) step(1'b1, 1'b1, 1'b0);
      repeat (30) step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      repeat (30) step(1'b1, 1'b1, 1'b1);
      chk("bp_beats", beats, 20);

      // Drain with two buffered words.
      for (int i = 0; i < 10; i++) push_word(8'($urandom));
      repeat (3) step(1'b1, 1'b1, 1'b0);
      beats     = 0;
      rd_pulses = 0;
      repeat (4) step(1'b1, 1'b0, 1'b1);
      chk("drain_beats", beats, 2);
      chk("drain_rd", rd_pulses, 0);
      chk("drain_busy", {31'd0, busy}, 32'd0);
      beats = 0;
      repeat (14) step(1'b1, 1'b1, 1'b1);
      chk("drain_rest", beats, 8);

      // Single-word FIFO.
      repeat (2) step(1'b1, 1'b1, 1'b1);
      push_word(8'hA5);
      rd_pulses = 0;
      beats     = 0;
      repeat (6) step(1'b1, 1'b1, 1'b1);
      chk("single_rd", rd_pulses, 1);
      chk("single_beats", beats, 1);

      // Reset while one word is buffered and one is in flight.
      for (int i = 0; i < 6; i++) push_word(8'($urandom));
      repeat (2) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      beats = 0;
      repeat (12) step(1'b1, 1'b1, 1'b1);
      chk("rst_beats", beats, 4);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0 && (wr_ptr - rd_ptr) < 10'd500)
            push_word(8'($urandom));
         step(1'($urandom_range(0, 63) != 0),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 2) != 0));
      end
      repeat (300) step(1'b1, 1'b1, 1'b1);
      chk("final_fifo_empty", {31'd0, fifo_empty}, 32'd1);
      chk("final_busy", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
